// File: rtl/rto_pkg.sv
// Shared types and field layout for the timestamp-ordered dispatch controller.
package rto_pkg;

    localparam int TS_WIDTH_DEF   = 64;
    localparam int DATA_WIDTH_DEF = 64;
    localparam int ENTRY_WIDTH    = 128;

    // FIFO word layout: timestamp in the upper field, payload in the lower field
    localparam int ENTRY_TS_MSB   = ENTRY_WIDTH - 1;
    localparam int ENTRY_TS_LSB   = DATA_WIDTH_DEF;
    localparam int ENTRY_DATA_MSB = DATA_WIDTH_DEF - 1;
    localparam int ENTRY_DATA_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/rto_dispatch_ctrl_if.sv
// FIFO read-side bundle between the dispatch controller and its entry FIFO.
interface rto_dispatch_ctrl_if;
    import rto_pkg::*;

    logic [ENTRY_WIDTH-1:0] fifo_dout;
    logic                   fifo_empty;
    logic                   fifo_rd_en;

    modport master (output fifo_rd_en, input fifo_dout, input fifo_empty);
    modport slave  (input fifo_rd_en, output fifo_dout, output fifo_empty);

endinterface

// File: rtl/rto_dispatch_ctrl_timer.sv
// Free-running timestamp counter with start/stop/clear control.
module rto_timer
    import rto_pkg::*;
#(
    parameter int TS_WIDTH = TS_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                timer_start,
    input  logic                timer_stop,
    input  logic                timer_clear,
    output logic [TS_WIDTH-1:0] timer_value,
    output logic                running
);

    // stop beats start; clear beats increment; increments wrap naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            running     <= 1'b0;
            timer_value <= '0;
        end else begin
            if (timer_stop) begin
                running <= 1'b0;
            end else if (timer_start) begin
                running <= 1'b1;
            end
            if (timer_clear) begin
                timer_value <= '0;
            end else if (running) begin
                timer_value <= timer_value + TS_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/rto_dispatch_ctrl.sv
// Releases FIFO entries when the timer reaches each entry's timestamp.
// Build option RTO_LATE_DISPATCH_EN: late entries are dispatched instead of dropped.
module rto_dispatch_ctrl
    import rto_pkg::*;
#(
    parameter int TS_WIDTH   = TS_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  timer_start,
    input  logic                  timer_stop,
    input  logic                  timer_clear,
    input  logic                  err_clear,
    rto_dispatch_ctrl_if.master   fifo,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic [TS_WIDTH-1:0]   timer_value,
    output logic                  running,
    output logic                  late_error,
    output logic                  busy
);

    // state | meaning
    // IDLE  | wait for a running timer and a non-empty FIFO, then issue a read
    // LOAD  | FIFO word arrives, latch timestamp and payload
    // WAIT  | compare timer against head timestamp; dispatch, or flag late

`ifdef RTO_LATE_DISPATCH_EN
    localparam bit LATE_DISPATCH = 1'b1;
`else
    localparam bit LATE_DISPATCH = 1'b0;
`endif

    state_t                state;
    state_t                state_nx;
    logic [TS_WIDTH-1:0]   head_ts;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  rd_en;
    logic                  dispatch;
    logic                  late_evt;

    rto_timer #(.TS_WIDTH(TS_WIDTH)) u_timer (
        .clk         (clk),
        .reset       (reset),
        .timer_start (timer_start),
        .timer_stop  (timer_stop),
        .timer_clear (timer_clear),
        .timer_value (timer_value),
        .running     (running)
    );

    always_comb begin
        state_nx = state;
        rd_en    = 1'b0;
        dispatch = 1'b0;
        late_evt = 1'b0;
        case (state)
            IDLE: begin
                if (running && !fifo.fifo_empty) begin
                    rd_en    = 1'b1;
                    state_nx = LOAD;
                end
            end
            LOAD: state_nx = WAIT;
            WAIT: begin
                if (timer_value == head_ts) begin
                    dispatch = 1'b1;
                    state_nx = IDLE;
                end else if (timer_value > head_ts) begin
                    late_evt = 1'b1;
                    dispatch = LATE_DISPATCH;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // a flushed entry is gone, so it can neither dispatch nor count as late
        if (flush) begin
            rd_en    = 1'b0;
            dispatch = 1'b0;
            late_evt = 1'b0;
            state_nx = IDLE;
        end
        if (reset) begin
            rd_en = 1'b0;
        end
    end

    assign fifo.fifo_rd_en = rd_en;
    assign busy            = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            head_ts    <= '0;
            head_data  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            late_error <= 1'b0;
        end else begin
            state     <= state_nx;
            out_valid <= dispatch;
            if (dispatch) begin
                out_data <= head_data;
            end
            if (flush) begin
                head_ts   <= '0;
                head_data <= '0;
            end else if (state == LOAD) begin
                head_ts   <= fifo.fifo_dout[ENTRY_TS_MSB:DATA_WIDTH];
                head_data <= fifo.fifo_dout[DATA_WIDTH-1:0];
            end
            if (late_evt) begin
                late_error <= 1'b1;
            end else if (err_clear) begin
                late_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rto_dispatch_ctrl.sv
// Self-checking bench for rto_dispatch_ctrl: table vectors, random entry streams, corner sequences.
module tb_rto_dispatch_ctrl;
    import rto_pkg::*;

`ifdef RTO_LATE_DISPATCH_EN
    localparam bit LATE_EN = 1'b1;
`else
    localparam bit LATE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        timer_start = 1'b0;
    logic        timer_stop = 1'b0;
    logic        timer_clear = 1'b0;
    logic        err_clear = 1'b0;
    logic [63:0] out_data;
    logic        out_valid;
    logic [63:0] timer_value;
    logic        running;
    logic        late_error;
    logic        busy;

    int vec_cnt = 0;
    int miscmp  = 0;

    always #5 clk = ~clk;

    rto_dispatch_ctrl_if fifo_if ();

    rto_dispatch_ctrl #(.TS_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .timer_start (timer_start),
        .timer_stop  (timer_stop),
        .timer_clear (timer_clear),
        .err_clear   (err_clear),
        .fifo        (fifo_if),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .timer_value (timer_value),
        .running     (running),
        .late_error  (late_error),
        .busy        (busy)
    );

    // standard FIFO model: word appears on dout the cycle after rd_en
    logic [127:0] fifo_mem [0:255];
    logic [7:0]   rd_ptr = 8'd0;
    logic [7:0]   wr_ptr = 8'd0;
    assign fifo_if.fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_if.fifo_rd_en && (rd_ptr != wr_ptr)) begin
            fifo_if.fifo_dout <= fifo_mem[rd_ptr];
            rd_ptr            <= rd_ptr + 8'd1;
        end
    end

    // dispatch monitor
    logic [63:0] mon_tv  [0:1023];
    logic [63:0] mon_dat [0:1023];
    int          disp_cnt = 0;

    always @(negedge clk) begin
        if (out_valid) begin
            mon_tv[disp_cnt % 1024]  <= timer_value;
            mon_dat[disp_cnt % 1024] <= out_data;
            disp_cnt                 <= disp_cnt + 1;
        end
    end

    typedef struct {
        int          grp;
        logic [63:0] ts;
        logic [63:0] data;
        bit          late;
        logic [63:0] exp_tv;
    } vec_t;

    vec_t        tbl [4];
    logic [63:0] exp_tv_q  [$];
    logic [63:0] exp_dat_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vec_cnt++;
        if (act !== req) begin
            miscmp++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        flush       = 1'b0;
        timer_start = 1'b0;
        timer_stop  = 1'b0;
        timer_clear = 1'b0;
        err_clear   = 1'b0;
        wr_ptr      = rd_ptr;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push(input logic [63:0] ts, input logic [63:0] data);
        fifo_mem[wr_ptr] = {ts, data};
        wr_ptr           = wr_ptr + 8'd1;
    endtask

    task automatic pulse_start();
        timer_start = 1'b1;
        @(negedge clk);
        timer_start = 1'b0;
    endtask

    task automatic wait_tv(input string name, input logic [63:0] v);
        int n = 0;
        while (timer_value != v && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(name, timer_value, v);
    endtask

    task automatic run_and_check(input string name, input bit exp_late);
        int base;
        int got;
        base = disp_cnt;
        pulse_start();
        repeat (300) @(negedge clk);
        got = disp_cnt - base;
        check({name, " count"}, 64'(got), 64'(exp_tv_q.size()));
        for (int i = 0; i < exp_tv_q.size() && i < got; i++) begin
            check($sformatf("%s tv[%0d]", name, i), mon_tv[(base + i) % 1024], exp_tv_q[i]);
            check($sformatf("%s data[%0d]", name, i), mon_dat[(base + i) % 1024], exp_dat_q[i]);
        end
        check({name, " late_error"}, {63'd0, late_error}, {63'd0, exp_late});
        check({name, " out_valid idle"}, {63'd0, out_valid}, 64'd0);
        if (exp_dat_q.size() > 0) begin
            check({name, " out_data hold"}, out_data, exp_dat_q[exp_dat_q.size() - 1]);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vec_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          el;
        int          base;
        logic [63:0] e;
        logic [63:0] ts;

        tbl[0] = '{grp: 0, ts: 64'd20, data: 64'hA5, late: 1'b0, exp_tv: 64'd21};
        tbl[1] = '{grp: 1, ts: 64'd10, data: 64'h11, late: 1'b0, exp_tv: 64'd11};
        tbl[2] = '{grp: 1, ts: 64'd11, data: 64'h22, late: 1'b1, exp_tv: 64'd14};
        tbl[3] = '{grp: 2, ts: 64'd1,  data: 64'h33, late: 1'b1, exp_tv: 64'd3};

        // reset values
        do_reset();
        check("rst out_valid",  {63'd0, out_valid}, 64'd0);
        check("rst out_data",   out_data, 64'd0);
        check("rst timer",      timer_value, 64'd0);
        check("rst running",    {63'd0, running}, 64'd0);
        check("rst late_error", {63'd0, late_error}, 64'd0);
        check("rst busy",       {63'd0, busy}, 64'd0);
        check("rst rd_en",      {63'd0, fifo_if.fifo_rd_en}, 64'd0);

        // table-driven groups
        for (int g = 0; g < 3; g++) begin
            do_reset();
            exp_tv_q.delete();
            exp_dat_q.delete();
            el = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (tbl[i].grp == g) begin
                    push(tbl[i].ts, tbl[i].data);
                    if (tbl[i].late) el = 1'b1;
                    if (!tbl[i].late || LATE_EN) begin
                        exp_tv_q.push_back(tbl[i].exp_tv);
                        exp_dat_q.push_back(tbl[i].data);
                    end
                end
            end
            run_and_check($sformatf("tbl grp%0d", g), el);
        end

        // random entry streams against a timeline model:
        // e is the earliest timer value at which the next entry can be compared
        for (int r = 0; r < 3; r++) begin
            do_reset();
            exp_tv_q.delete();
            exp_dat_q.delete();
            el = 1'b0;
            e  = 64'd2;
            ts = 64'($urandom_range(0, 5));
            for (int i = 0; i < 20; i++) begin
                logic [63:0] d;
                d = {$urandom, $urandom};
                push(ts, d);
                if (ts >= e) begin
                    exp_tv_q.push_back(ts + 64'd1);
                    exp_dat_q.push_back(d);
                    e = ts + 64'd3;
                end else begin
                    el = 1'b1;
                    if (LATE_EN) begin
                        exp_tv_q.push_back(e + 64'd1);
                        exp_dat_q.push_back(d);
                    end
                    e = e + 64'd3;
                end
                ts = ts + 64'($urandom_range(0, 6));
            end
            run_and_check($sformatf("rand%0d", r), el);
        end

        // flush while waiting: nothing dispatched, timer keeps counting
        do_reset();
        push(64'd50, 64'hBEEF);
        base = disp_cnt;
        pulse_start();
        wait_tv("flush reach 40", 64'd40);
        check("flush busy before", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush timer", timer_value, 64'd41);
        check("flush busy after", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        check("flush no dispatch", 64'(disp_cnt - base), 64'd0);

        // flush in IDLE blocks the pending read
        do_reset();
        push(64'd30, 64'h5A);
        base        = disp_cnt;
        flush       = 1'b1;
        timer_start = 1'b1;
        @(negedge clk);
        timer_start = 1'b0;
        repeat (3) @(negedge clk);
        check("idle flush fifo not read", {63'd0, fifo_if.fifo_empty}, 64'd0);
        check("idle flush busy", {63'd0, busy}, 64'd0);
        flush = 1'b0;
        repeat (60) @(negedge clk);
        check("idle flush later count", 64'(disp_cnt - base), 64'd1);
        check("idle flush later tv", mon_tv[base % 1024], 64'd31);

        // timer start/stop/clear priority
        do_reset();
        timer_start = 1'b1;
        timer_stop  = 1'b1;
        @(negedge clk);
        timer_start = 1'b0;
        timer_stop  = 1'b0;
        check("start+stop running", {63'd0, running}, 64'd0);
        pulse_start();
        repeat (4) @(negedge clk);
        check("timer counting", timer_value, 64'd4);
        timer_clear = 1'b1;
        @(negedge clk);
        timer_clear = 1'b0;
        check("clear to zero", timer_value, 64'd0);
        @(negedge clk);
        check("clear then one", timer_value, 64'd1);
        timer_stop = 1'b1;
        @(negedge clk);
        timer_stop = 1'b0;
        repeat (3) @(negedge clk);
        check("stop running", {63'd0, running}, 64'd0);
        check("stop frozen", timer_value, 64'd2);

        // reset while waiting discards the entry
        do_reset();
        push(64'd100, 64'h77);
        base = disp_cnt;
        pulse_start();
        wait_tv("rst reach 60", 64'd60);
        check("rst mid busy", {63'd0, busy}, 64'd1);
        reset       = 1'b1;
        timer_start = 1'b1;
        err_clear   = 1'b0;
        @(negedge clk);
        reset       = 1'b0;
        timer_start = 1'b0;
        check("rst mid timer",   timer_value, 64'd0);
        check("rst mid running", {63'd0, running}, 64'd0);
        check("rst mid busy 0",  {63'd0, busy}, 64'd0);
        check("rst mid valid",   {63'd0, out_valid}, 64'd0);
        check("rst mid data",    out_data, 64'd0);
        pulse_start();
        repeat (150) @(negedge clk);
        check("rst mid no dispatch", 64'(disp_cnt - base), 64'd0);

        // late event coinciding with err_clear keeps the flag
        do_reset();
        push(64'd1, 64'h99);
        pulse_start();
        wait_tv("late reach 2", 64'd2);
        check("late not yet", {63'd0, late_error}, 64'd0);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("late wins over clear", {63'd0, late_error}, 64'd1);
        repeat (3) @(negedge clk);
        check("late sticky", {63'd0, late_error}, 64'd1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("err_clear alone", {63'd0, late_error}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
